ti_quad_layer_pipe: RTL
=======================

// Module: ti_quad_layer_pipe
// PURPOSE
//  Pipelined 3-share second-order TI of the Midori S-box quadratic layer, for NIBBLES parallel S-boxes.
//  Unshared map per nibble, input bits {a,b,c,d} = x[3:0]:
//    y0 = d^c^db;  y1 = c^db;  y2 = b^dc^db;  y3 = a^b^dc^db.
//  Stage 1 registers nine component functions per output bit. Stage 2 compresses them to 3 shares.
//  The block sits between the linear/affine masked layers of the shared S-box datapath.
// PARAMETERS
//  NIBBLES  16  number of parallel 4-bit shared S-boxes (>=1)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous, active-low reset
//  in_valid   in   1            input shares valid
//  in_ready   out  1            block accepts input this cycle
//  in_sh      in   12*NIBBLES   input shares; share s(0..2) of bit k of nibble n = in_sh[s*4*NIBBLES+4n+k]
//  out_valid  out  1            output shares valid
//  out_ready  in   1            downstream accepts output
//  out_sh     out  12*NIBBLES   output shares, same layout as in_sh
//  rnd        in   8*NIBBLES    fresh randomness; present only with TI_REFRESH_EN (see CONFIGURATION)
// BEHAVIOUR
//  Component c_ij (i,j = 1..3) of each bit uses only d_i and one share index j of b/c/a. This gives non-completeness.
//  Quadratic terms: y0,y1: d_i&b_j.  y2,y3: d_i&(c_j^b_j).  Linear terms added per (i,j):
//    y0: 11 d1^b1 | 12 c2^b2 | 21 c1 | 22 b2^d2 | 31 b1 | 33 d3^c3
//    y1: 11 b1 | 12 b2^c2 | 21 c1 | 22 b2 | 31 b1 | 33 c3
//    y2: 11 c1 | 12 b2^c2 | 21 b1^c1 | 23 c3 | 32 c2 | 33 b3^c3
//    y3: 11 a1 | 12 b2^a2 | 21 b1^a1 | 23 c3 | 31 a1 | 33 a3^b3^c3
//  Any unlisted c_ij carries only its quadratic term.
//  Stage 1 (s1): on accept, register all 36*NIBBLES components; s1_valid <= 1.
//  Stage 2 (s2): output share i = c_i1^c_i2^c_i3 of the s1 register, registered into out_sh; out_valid = s2_valid.
//  No combinational path from in_sh to out_sh; the compression XOR is fed only from the s1 flops.
//  Latency: exactly 2 cycles from accept (in_valid&in_ready) to out_valid with no backpressure; throughput 1/cycle.
//  Handshake rules:
//   - s2 advances when !s2_valid | out_ready.
//   - s1 advances when !s1_valid | s2 advances.
//   - in_ready = !s1_valid | s2 advances. in_ready does not depend on in_valid.
//   - Stalled stages hold data stable; out_sh/out_valid hold until out_ready.
//   - Simultaneous pop at s2 and push at s1 in one cycle: both occur, no bubble.
//   - Pipeline full and out_ready=0: in_ready=0; in_sh is ignored even if in_valid=1.
//  Reset (async assert, sync-deasserted externally): s1/s2 valid=0, all data regs=0, out_valid=0, out_sh=0.
//   - in_ready=1 from the first cycle after reset.
//   - Reset mid-operation discards in-flight data; nothing partial is ever output.
//  Widths: all operations are bitwise GF(2). No arithmetic and no wrap-around.
// CONFIGURATION
//  TI_REFRESH_EN defined:
//   - Port rnd is present and sampled on accept.
//   - Per output bit, with r1,r2 = 2 rnd bits: c_11 ^= r1, c_21 ^= r2, c_31 ^= r1^r2 before the s1 register.
//   - The unshared output is unchanged; output shares are re-randomised.
//  TI_REFRESH_EN undefined: port rnd absent; components registered as listed above.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, out_sh=0 immediately; in_ready=1 the first cycle after release.
//  2 Function: NIBBLES=1, random 3-share split of x=0xD -> after 2 cycles XOR of shares = 0xA.
//    x=0x0 -> 0x0; x=0xF -> 0x5. Sweep all 16 x against the equations with random masks.
//  3 Throughput: in_valid=1, out_ready=1 for 20 cycles -> 20 outputs in order, first at cycle 2, no bubbles.
//  4 Backpressure: out_ready=0 for 5 cycles with 3 items offered -> accepts 2, then in_ready=0.
//    out_sh stays stable. On release, all items exit in order, none lost or duplicated.
//  5 Simultaneous: full pipe, out_ready=1 and in_valid=1 in the same cycle -> pop and push both occur; occupancy unchanged.
//  6 TI_REFRESH_EN: same input with rnd=0 vs rnd=all-ones -> output shares differ; unshared XOR identical.

Source files
------------

// File: rtl/ti_quad_layer_pipe.sv
// Two-stage 3-share threshold implementation of the Midori S-box quadratic layer for NIBBLES S-boxes.
// Define TI_REFRESH_EN to add port rnd, which re-randomises the output shares without changing the unshared value.
module ti_quad_layer_pipe #(
  parameter int NIBBLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [12*NIBBLES-1:0]   in_sh,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [12*NIBBLES-1:0]   out_sh
`ifdef TI_REFRESH_EN
  ,
  input  logic [8*NIBBLES-1:0]    rnd
`endif
);

  localparam int SW = 4 * NIBBLES;
  localparam int CW = 36 * NIBBLES;

  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  logic          accept;
  logic [CW-1:0] comp_next;
  logic [CW-1:0] s1_comp;
  logic [12*NIBBLES-1:0] out_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && s1_adv;
  assign out_valid = s2_valid;

  // Component c_ij of output bit k in nibble n; i selects the d share, j the b/c/a share.
  function automatic int ci(input int n, input int k, input int i, input int j);
    return 36 * n + 9 * k + 3 * i + j;
  endfunction

  always_comb begin
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    logic [2:0] d;
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    comp_next = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      for (int s = 0; s < 3; s++) begin
        d[s] = in_sh[s*SW + 4*n + 0];
        c[s] = in_sh[s*SW + 4*n + 1];
        b[s] = in_sh[s*SW + 4*n + 2];
        a[s] = in_sh[s*SW + 4*n + 3];
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          comp_next[ci(n, 0, i, j)] = d[i] & b[j];
          comp_next[ci(n, 1, i, j)] = d[i] & b[j];
          comp_next[ci(n, 2, i, j)] = d[i] & (c[j] ^ b[j]);
          comp_next[ci(n, 3, i, j)] = d[i] & (c[j] ^ b[j]);
        end
      end
      // Linear terms are spread so that each component still sees a single share index j.
      comp_next[ci(n, 0, 0, 0)] ^= d[0] ^ b[0];
      comp_next[ci(n, 0, 0, 1)] ^= c[1] ^ b[1];
      comp_next[ci(n, 0, 1, 0)] ^= c[0];
      comp_next[ci(n, 0, 1, 1)] ^= b[1] ^ d[1];
      comp_next[ci(n, 0, 2, 0)] ^= b[0];
      comp_next[ci(n, 0, 2, 2)] ^= d[2] ^ c[2];

      comp_next[ci(n, 1, 0, 0)] ^= b[0];
      comp_next[ci(n, 1, 0, 1)] ^= b[1] ^ c[1];
      comp_next[ci(n, 1, 1, 0)] ^= c[0];
      comp_next[ci(n, 1, 1, 1)] ^= b[1];
      comp_next[ci(n, 1, 2, 0)] ^= b[0];
      comp_next[ci(n, 1, 2, 2)] ^= c[2];

      comp_next[ci(n, 2, 0, 0)] ^= c[0];
      comp_next[ci(n, 2, 0, 1)] ^= b[1] ^ c[1];
      comp_next[ci(n, 2, 1, 0)] ^= b[0] ^ c[0];
      comp_next[ci(n, 2, 1, 2)] ^= c[2];
      comp_next[ci(n, 2, 2, 1)] ^= c[1];
      comp_next[ci(n, 2, 2, 2)] ^= b[2] ^ c[2];

      comp_next[ci(n, 3, 0, 0)] ^= a[0];
      comp_next[ci(n, 3, 0, 1)] ^= b[1] ^ a[1];
      comp_next[ci(n, 3, 1, 0)] ^= b[0] ^ a[0];
      comp_next[ci(n, 3, 1, 2)] ^= c[2];
      comp_next[ci(n, 3, 2, 0)] ^= a[0];
      comp_next[ci(n, 3, 2, 2)] ^= a[2] ^ b[2] ^ c[2];
`ifdef TI_REFRESH_EN
      for (int k = 0; k < 4; k++) begin
        comp_next[ci(n, k, 0, 0)] ^= rnd[8*n + 2*k];
        comp_next[ci(n, k, 1, 0)] ^= rnd[8*n + 2*k + 1];
        comp_next[ci(n, k, 2, 0)] ^= rnd[8*n + 2*k] ^ rnd[8*n + 2*k + 1];
      end
`endif
    end
  end

  // Compression reads only the stage-1 flops, so glitches cannot combine shares across the register.
  always_comb begin
    out_next = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      for (int k = 0; k < 4; k++) begin
        for (int s = 0; s < 3; s++) begin
          out_next[s*SW + 4*n + k] = s1_comp[ci(n, k, s, 0)] ^ s1_comp[ci(n, k, s, 1)]
                                   ^ s1_comp[ci(n, k, s, 2)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_comp  <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) s1_comp <= comp_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sh   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) out_sh <= out_next;
    end
  end

endmodule
